// File: rtl/pcie_rx_merger.sv
// Merges FIFOs 4..7 into one registered stream using round-robin arbitration with a
// burst limit and ready/valid backpressure; also keeps a readable pop counter per port.
module pcie_rx_merger #(
  parameter int DATA_BITS = 10,
  parameter int MAX_BURST = 4,
  parameter int CNT_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [DATA_BITS-1:0] fifo4_out,
  input  logic [DATA_BITS-1:0] fifo5_out,
  input  logic [DATA_BITS-1:0] fifo6_out,
  input  logic [DATA_BITS-1:0] fifo7_out,
  input  logic                 empty4,
  input  logic                 empty5,
  input  logic                 empty6,
  input  logic                 empty7,
  output logic                 pop4,
  output logic                 pop5,
  output logic                 pop6,
  output logic                 pop7,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic [1:0]           src_out,
  input  logic                 req,
  input  logic [1:0]           idx,
  output logic [CNT_BITS-1:0]  counter_out,
  output logic                 counter_valid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [0:0]    state_reg;
  logic [1:0]    ptr_reg;
  logic [1:0]    cur_reg;
  logic [BW-1:0] burst_cnt_reg;

  logic [3:0][DATA_BITS-1:0] heads;
  logic [3:0]                avail;
  logic                      load;
  logic                      pop_en;

  assign heads  = {fifo7_out, fifo6_out, fifo5_out, fifo4_out};
  assign avail  = ~{empty7, empty6, empty5, empty4};
  assign load   = ~valid_out | ready_in;
  assign pop_en = reset & load & ~init;

  // Keep feeding the current port until it empties or reaches the burst limit.
  logic stay;
  assign stay = (state_reg == ST_BURST) && avail[cur_reg] && (burst_cnt_reg < BURST_MAX);

  // Rotating priority scan; the lowest offset from scan_base wins.
  logic [1:0] scan_base;
  logic [1:0] scan_port;
  logic [1:0] cand;
  logic       scan_found;
  always_comb begin
    scan_base  = (state_reg == ST_IDLE) ? ptr_reg : cur_reg + 2'd1;
    scan_port  = scan_base;
    scan_found = 1'b0;
    cand       = scan_base;
    for (int k = 3; k >= 0; k--) begin
      cand = scan_base + 2'(k);
      if (avail[cand]) begin
        scan_found = 1'b1;
        scan_port  = cand;
      end
    end
  end

  logic       grant_any;
  logic [1:0] grant_port;
  logic [3:0] pop_vec;
  assign grant_any  = stay | scan_found;
  assign grant_port = stay ? cur_reg : scan_port;
  assign pop_vec    = (pop_en && grant_any) ? (4'b0001 << grant_port) : 4'b0000;
  assign {pop7, pop6, pop5, pop4} = pop_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      cur_reg       <= '0;
      burst_cnt_reg <= '0;
      valid_out     <= 1'b0;
      data_out      <= '0;
      src_out       <= '0;
    end else if (init) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      cur_reg       <= '0;
      burst_cnt_reg <= '0;
      valid_out     <= 1'b0;
    end else if (load) begin
      valid_out <= grant_any;
      if (grant_any) begin
        data_out <= heads[grant_port];
        src_out  <= grant_port;
      end
      if (stay) begin
        burst_cnt_reg <= burst_cnt_reg + BW'(1);
      end else begin
        if (state_reg == ST_BURST) ptr_reg <= cur_reg + 2'd1;
        if (scan_found) begin
          state_reg     <= ST_BURST;
          cur_reg       <= scan_port;
          burst_cnt_reg <= BW'(1);
        end else begin
          state_reg <= ST_IDLE;
        end
      end
    end
  end

  logic [3:0][CNT_BITS-1:0] cnt_vals;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_BITS-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)           cnt_reg <= '0;
        else if (init)        cnt_reg <= '0;
        else if (pop_vec[gi]) cnt_reg <= cnt_reg + CNT_BITS'(1);
      end
      assign cnt_vals[gi] = cnt_reg;
    end
  endgenerate

  // Sampling before the increment lands returns the pre-increment value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_out   <= '0;
      counter_valid <= 1'b0;
    end else if (init) begin
      counter_valid <= 1'b0;
    end else begin
      counter_valid <= req;
      if (req) counter_out <= cnt_vals[idx];
    end
  end

endmodule

// File: tb/tb_pcie_rx_merger.sv
// Directed bench for pcie_rx_merger: FIFO queues, a transaction-level expected stream
// and a per-cycle compare process, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_pcie_rx_merger;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic       ready_in = 1'b1;
  logic       req = 1'b0;
  logic [1:0] idx = 2'd0;
  logic [9:0] f4, f5, f6, f7;
  logic       e4, e5, e6, e7;
  logic       p4, p5, p6, p7;
  logic [9:0] data_out;
  logic       valid_out;
  logic [1:0] src_out;
  logic [4:0] counter_out;
  logic       counter_valid;

  always #5 clk = ~clk;

  pcie_rx_merger dut (
    .clk(clk), .reset(reset), .init(init),
    .fifo4_out(f4), .fifo5_out(f5), .fifo6_out(f6), .fifo7_out(f7),
    .empty4(e4), .empty5(e5), .empty6(e6), .empty7(e7),
    .pop4(p4), .pop5(p5), .pop6(p6), .pop7(p7),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .req(req), .idx(idx), .counter_out(counter_out), .counter_valid(counter_valid)
  );

  typedef struct packed {logic [1:0] src; logic [9:0] data;} ent_t;

  logic [9:0] q0[$], q1[$], q2[$], q3[$];
  ent_t exp_q[$];
  ent_t acc_log[$];
  int   acc_cyc[$];
  int   total = 0, bad = 0, cyc = 0;
  logic [3:0] pend_pop = 4'b0;
  int   mcnt[4] = '{0, 0, 0, 0};
  logic exp_cv = 1'b0;
  logic [4:0] exp_co = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [9:0] getq(input int p, input int k);
    case (p)
      0: return q0[k];
      1: return q1[k];
      2: return q2[k];
      default: return q3[k];
    endcase
  endfunction

  task automatic refresh();
    e4 = (q0.size() == 0); f4 = e4 ? 10'd0 : q0[0];
    e5 = (q1.size() == 0); f5 = e5 ? 10'd0 : q1[0];
    e6 = (q2.size() == 0); f6 = e6 ? 10'd0 : q2[0];
    e7 = (q3.size() == 0); f7 = e7 ? 10'd0 : q3[0];
  endtask

  task automatic fill(input int p, input int n, input logic [9:0] base);
    for (int k = 0; k < n; k++) begin
      case (p)
        0: q0.push_back(base + 10'(k));
        1: q1.push_back(base + 10'(k));
        2: q2.push_back(base + 10'(k));
        default: q3.push_back(base + 10'(k));
      endcase
    end
  endtask

  // Expected output order from queue contents, arbitration starting at FIFO4.
  task automatic rebuild();
    int rem[4];
    int taken[4];
    int pos, c, n, left;
    logic found;
    ent_t e;
    exp_q.delete();
    rem[0] = q0.size(); rem[1] = q1.size(); rem[2] = q2.size(); rem[3] = q3.size();
    taken = '{0, 0, 0, 0};
    left = rem[0] + rem[1] + rem[2] + rem[3];
    pos = 0;
    while (left > 0) begin
      found = 1'b0;
      c = pos;
      for (int k = 0; k < 4; k++) begin
        if (!found && rem[(pos + k) % 4] > 0) begin
          found = 1'b1;
          c = (pos + k) % 4;
        end
      end
      n = (rem[c] < MAXB) ? rem[c] : MAXB;
      for (int j = 0; j < n; j++) begin
        e.src = 2'(c);
        e.data = getq(c, taken[c]);
        exp_q.push_back(e);
        taken[c]++;
        rem[c]--;
        left--;
      end
      pos = (c + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_pop[0]) void'(q0.pop_front());
    if (pend_pop[1]) void'(q1.pop_front());
    if (pend_pop[2]) void'(q2.pop_front());
    if (pend_pop[3]) void'(q3.pop_front());
    refresh();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    refresh();
    tick();
    tick();
    reset = 1'b1;
    rebuild();
  endtask

  // Per-cycle compare against the expected stream and counter model.
  always @(negedge clk) begin
    logic [3:0] act_pop;
    logic [3:0] want_pop;
    logic       ld;
    int         nidx;
    ent_t       got;
    cyc++;
    act_pop = {p7, p6, p5, p4};
    if (!reset) begin
      chk("rst_pop", act_pop, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_cvalid", counter_valid, 0);
      exp_cv = 1'b0;
      exp_co = 5'd0;
      mcnt = '{0, 0, 0, 0};
      pend_pop = 4'b0;
    end else begin
      chk("cnt_valid", counter_valid, exp_cv);
      chk("cnt_out", counter_out, exp_co);
      if (valid_out) begin
        chk("have_exp", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("data", data_out, exp_q[0].data);
          chk("src", src_out, exp_q[0].src);
        end
      end
      ld = !valid_out || ready_in;
      nidx = valid_out ? 1 : 0;
      want_pop = (ld && !init && exp_q.size() > nidx) ? (4'b0001 << exp_q[nidx].src) : 4'b0;
      chk("pop", act_pop, want_pop);
      if (init) begin
        exp_cv = 1'b0;
        mcnt = '{0, 0, 0, 0};
      end else begin
        if (req) begin
          exp_cv = 1'b1;
          exp_co = 5'(mcnt[idx]);
        end else begin
          exp_cv = 1'b0;
        end
        for (int p = 0; p < 4; p++) if (act_pop[p]) mcnt[p] = (mcnt[p] + 1) % 32;
      end
      if (valid_out && ready_in) begin
        got.src = src_out;
        got.data = data_out;
        acc_log.push_back(got);
        acc_cyc.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      pend_pop = act_pop;
    end
  end

  int exp_src[24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};

  initial begin
    refresh();
    tick();
    tick();
    chk("reset_data", data_out, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_src", src_out, 0);
    chk("reset_cout", counter_out, 0);
    chk("reset_cvalid", counter_valid, 0);
    reset = 1'b1;
    rebuild();

    // single port
    fill(1, 3, 10'h101);
    refresh();
    rebuild();
    #1;
    chk("t2_pop5", p5, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_valid", valid_out, 1);
      chk("t2_data", data_out, 10'h101 + 10'(k));
      chk("t2_src", src_out, 1);
    end
    tick();
    chk("t2_idle", valid_out, 0);
    req = 1'b1; idx = 2'd1;
    tick();
    req = 1'b0;
    chk("t2_cnt5", counter_out, 3);
    chk("t2_cvalid", counter_valid, 1);
    tick();
    chk("t2_cvalid_drop", counter_valid, 0);
    chk("t2_drained", exp_q.size(), 0);

    // fairness
    do_reset();
    for (int p = 0; p < 4; p++) fill(p, 6, 10'(p * 256));
    refresh();
    rebuild();
    acc_log.delete();
    acc_cyc.delete();
    repeat (30) tick();
    chk("t3_count", acc_log.size(), 24);
    for (int i = 0; i < 24 && i < acc_log.size(); i++) begin
      chk("t3_order", acc_log[i].src, exp_src[i]);
      chk("t3_nogap", acc_cyc[i], acc_cyc[0] + i);
    end
    if (acc_log.size() > 16) chk("t3_word16", acc_log[16].data, 10'h004);
    for (int p = 0; p < 4; p++) begin
      req = 1'b1; idx = 2'(p);
      tick();
      chk("t3_cnt", counter_out, 6);
    end
    req = 1'b0;
    tick();
    chk("t3_drained", exp_q.size(), 0);

    // backpressure
    do_reset();
    fill(2, 4, 10'h2a0);
    refresh();
    rebuild();
    tick();
    chk("t4_first", data_out, 10'h2a0);
    ready_in = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold", data_out, 10'h2a0);
      chk("t4_hold_valid", valid_out, 1);
      chk("t4_nopop", p6, 0);
    end
    ready_in = 1'b1;
    tick();
    chk("t4_next", data_out, 10'h2a1);
    repeat (4) tick();
    chk("t4_drained", exp_q.size(), 0);

    // reset mid-traffic
    do_reset();
    for (int p = 0; p < 4; p++) fill(p, 6, 10'(p * 256));
    refresh();
    rebuild();
    tick();
    tick();
    req = 1'b1; idx = 2'd0;
    tick();
    req = 1'b0;
    chk("t1_cnt_before", counter_out, 2);
    reset = 1'b0;
    #1;
    chk("t1_data", data_out, 0);
    chk("t1_valid", valid_out, 0);
    chk("t1_src", src_out, 0);
    chk("t1_pops", {p7, p6, p5, p4}, 0);
    chk("t1_cout", counter_out, 0);
    chk("t1_cvalid", counter_valid, 0);
    repeat (3) tick();
    reset = 1'b1;
    rebuild();
    tick();
    chk("t1_resume_src", src_out, 0);
    chk("t1_resume_data", data_out, 10'h003);
    repeat (30) tick();
    chk("t1_drained", exp_q.size(), 0);

    // counter wrap
    do_reset();
    fill(3, 33, 10'h000);
    refresh();
    rebuild();
    repeat (40) tick();
    req = 1'b1; idx = 2'd3;
    tick();
    req = 1'b0;
    chk("t5_wrap", counter_out, 1);
    chk("t5_cvalid", counter_valid, 1);
    tick();
    chk("t5_cvalid_pulse", counter_valid, 0);
    chk("t5_drained", exp_q.size(), 0);

    // init during burst
    do_reset();
    for (int p = 0; p < 4; p++) fill(p, 6, 10'(p * 256));
    refresh();
    rebuild();
    repeat (6) tick();
    init = 1'b1; req = 1'b1; idx = 2'd0;
    tick();
    chk("t6_valid", valid_out, 0);
    chk("t6_cvalid", counter_valid, 0);
    init = 1'b0; idx = 2'd1;
    rebuild();
    tick();
    req = 1'b0;
    chk("t6_restart_valid", valid_out, 1);
    chk("t6_restart_src", src_out, 0);
    chk("t6_cnt_cleared", counter_out, 0);
    chk("t6_cvalid_after", counter_valid, 1);
    repeat (30) tick();
    chk("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
